// File: rtl/opendap_ap_router.sv
// Routes the SW-DP's single AP access port to one of N_APS downstream APs,
// tracks completion, broadcasts aborts and force-aborts a hung AP via a watchdog.
module opendap_ap_router #(
    parameter int   N_APS      = 2,
    parameter int   TIMEOUT    = 1024,
    parameter logic UNIMPL_ERR = 1'b0
) (
    input  logic                  swclk,
    input  logic                  rst_n,
    input  logic [7:0]            up_sel,
    input  logic [5:0]            up_addr,
    input  logic [31:0]           up_wdata,
    input  logic                  up_wen,
    input  logic                  up_ren,
    input  logic                  up_abort,
    output logic [31:0]           up_rdata,
    output logic                  up_rdy,
    output logic                  up_err,
    output logic [5:0]            dn_addr,
    output logic [31:0]           dn_wdata,
    output logic [N_APS-1:0]      dn_wen,
    output logic [N_APS-1:0]      dn_ren,
    output logic [N_APS-1:0]      dn_abort,
    input  logic [32*N_APS-1:0]   dn_rdata,
    input  logic [N_APS-1:0]      dn_rdy,
    input  logic [N_APS-1:0]      dn_err
);
    localparam int SW  = (N_APS > 1) ? $clog2(N_APS) : 1;
    localparam int WDW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_NULL, ST_TOUT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cur_sel_q, cur_sel_d;
    logic            is_read_q, is_read_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            sel_rdy, sel_err, sel_ok, wd_fire;
    logic [31:0]     sel_rdata;
    logic [N_APS-1:0] wen_c, ren_c, wd_abort_c;

    assign dn_addr  = up_addr;
    assign dn_wdata = up_wdata;
    assign sel_ok   = ({1'b0, up_sel} < 9'(N_APS));

    // Mux the tracked AP's return signals and build its one-hot abort mask.
    always_comb begin
        sel_rdy    = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        wd_abort_c = '0;
        for (int i = 0; i < N_APS; i++) begin
            if (cur_sel_q == SW'(i)) begin
                sel_rdy       = dn_rdy[i];
                sel_err       = dn_err[i];
                sel_rdata     = dn_rdata[32*i +: 32];
                wd_abort_c[i] = wd_fire;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        is_read_d = is_read_q;
        wdog_d    = wdog_q;
        rdata_d   = rdata_q;
        up_rdy    = 1'b1;
        up_err    = 1'b0;
        up_rdata  = rdata_q;
        wen_c     = '0;
        ren_c     = '0;
        wd_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((up_wen || up_ren) && !up_abort) begin
                    if (sel_ok) begin
                        // Simultaneous wen/ren is illegal and is handled as a write.
                        for (int i = 0; i < N_APS; i++) begin
                            wen_c[i] = up_wen && (up_sel == 8'(i));
                            ren_c[i] = up_ren && !up_wen && (up_sel == 8'(i));
                        end
                        cur_sel_d = up_sel[SW-1:0];
                        is_read_d = !up_wen;
                        wdog_d    = '0;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d = ST_NULL;
                    end
                end
            end
            ST_BUSY: begin
                up_rdy = sel_rdy;
                if (sel_rdy) begin
                    up_err   = sel_err;
                    up_rdata = sel_rdata;
                    if (is_read_q) rdata_d = sel_rdata;
                    state_d = ST_IDLE;
                end else begin
                    if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
                    if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
                        wd_fire = 1'b1;
                        state_d = ST_TOUT;
                    end
                end
            end
            ST_NULL: begin
                up_err   = UNIMPL_ERR;
                up_rdata = '0;
                rdata_d  = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                up_err   = 1'b1;
                up_rdata = '0;
                rdata_d  = '0;
                state_d  = ST_IDLE;
            end
        endcase
        if (up_abort) begin
            state_d = ST_IDLE;
            rdata_d = rdata_q;
        end
        // While in reset, present the idle face upstream and keep every AP quiet.
        if (!rst_n) begin
            up_rdy   = 1'b1;
            up_err   = 1'b0;
            up_rdata = '0;
        end
    end

    assign dn_wen   = rst_n ? wen_c : '0;
    assign dn_ren   = rst_n ? ren_c : '0;
    assign dn_abort = rst_n ? ({N_APS{up_abort}} | wd_abort_c) : '0;

    always_ff @(posedge swclk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
            is_read_q <= 1'b0;
            wdog_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            is_read_q <= is_read_d;
            wdog_q    <= wdog_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_opendap_ap_router.sv
// Directed bench for opendap_ap_router: N_APS=2, TIMEOUT=8, with a second
// instance (UNIMPL_ERR=1) sharing all inputs to cover the unimplemented-APSEL error value.
module tb_opendap_ap_router;
    logic        swclk = 1'b0;
    logic        rst_n;
    logic [7:0]  up_sel;
    logic [5:0]  up_addr;
    logic [31:0] up_wdata;
    logic        up_wen, up_ren, up_abort;
    logic [63:0] dn_rdata;
    logic [1:0]  dn_rdy, dn_err;

    logic [31:0] up_rdata, u1_up_rdata;
    logic        up_rdy, up_err, u1_up_rdy, u1_up_err;
    logic [5:0]  dn_addr, u1_dn_addr;
    logic [31:0] dn_wdata, u1_dn_wdata;
    logic [1:0]  dn_wen, dn_ren, dn_abort;
    logic [1:0]  u1_dn_wen, u1_dn_ren, u1_dn_abort;

    int checks = 0;
    int errors = 0;

    always #5 swclk = ~swclk;

    opendap_ap_router #(.N_APS(2), .TIMEOUT(8), .UNIMPL_ERR(1'b0)) u_dut (
        .swclk(swclk), .rst_n(rst_n), .up_sel(up_sel), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(up_rdata), .up_rdy(up_rdy), .up_err(up_err),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_wen(dn_wen), .dn_ren(dn_ren),
        .dn_abort(dn_abort), .dn_rdata(dn_rdata), .dn_rdy(dn_rdy), .dn_err(dn_err)
    );

    opendap_ap_router #(.N_APS(2), .TIMEOUT(8), .UNIMPL_ERR(1'b1)) u_dut1 (
        .swclk(swclk), .rst_n(rst_n), .up_sel(up_sel), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(u1_up_rdata), .up_rdy(u1_up_rdy), .up_err(u1_up_err),
        .dn_addr(u1_dn_addr), .dn_wdata(u1_dn_wdata), .dn_wen(u1_dn_wen), .dn_ren(u1_dn_ren),
        .dn_abort(u1_dn_abort), .dn_rdata(dn_rdata), .dn_rdy(dn_rdy), .dn_err(dn_err)
    );

    // Inputs change 1ns after the rising edge; checks run 1ns later.
    task automatic cyc();
        @(posedge swclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0; up_sel = 8'd0; up_addr = 6'd0; up_wdata = 32'd0;
        up_wen = 1'b0; up_ren = 1'b0; up_abort = 1'b0;
        dn_rdata = 64'd0; dn_rdy = 2'b00; dn_err = 2'b00;

        // Reset: strobes gated even with a write request present
        cyc(); cyc();
        up_wen = 1'b1;
        #1;
        chk("rst_dn_wen", 32'(dn_wen), 32'h0);
        chk("rst_dn_abort", 32'(dn_abort), 32'h0);
        cyc();
        rst_n = 1'b1; up_wen = 1'b0;
        #1;
        chk("rst_up_rdy", 32'(up_rdy), 32'h1);
        chk("rst_up_err", 32'(up_err), 32'h0);
        chk("rst_up_rdata", up_rdata, 32'h0);

        // Read AP1, three stall cycles
        cyc();
        up_ren = 1'b1; up_sel = 8'd1; up_addr = 6'h0C;
        #1;
        chk("rd1_dn_ren", 32'(dn_ren), 32'h2);
        chk("rd1_dn_wen", 32'(dn_wen), 32'h0);
        chk("rd1_dn_addr", 32'(dn_addr), 32'h0C);
        chk("rd1_issue_rdy", 32'(up_rdy), 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            up_ren = 1'b0;
            #1;
            chk("rd1_stall_rdy", 32'(up_rdy), 32'h0);
            chk("rd1_stall_ren", 32'(dn_ren), 32'h0);
        end
        cyc();
        dn_rdy = 2'b10; dn_rdata = {32'hCAFEF00D, 32'h0};
        #1;
        chk("rd1_done_rdy", 32'(up_rdy), 32'h1);
        chk("rd1_done_rdata", up_rdata, 32'hCAFEF00D);
        chk("rd1_done_err", 32'(up_err), 32'h0);
        cyc();
        dn_rdy = 2'b00; dn_rdata = 64'd0;
        #1;
        chk("rd1_hold_rdata", up_rdata, 32'hCAFEF00D);
        chk("rd1_hold_rdy", 32'(up_rdy), 32'h1);

        // Write AP0 that completes with error
        cyc();
        up_wen = 1'b1; up_sel = 8'd0; up_wdata = 32'h12345678;
        #1;
        chk("wr0_dn_wen", 32'(dn_wen), 32'h1);
        chk("wr0_dn_ren", 32'(dn_ren), 32'h0);
        chk("wr0_dn_wdata", dn_wdata, 32'h12345678);
        cyc();
        up_wen = 1'b0; dn_rdy = 2'b01; dn_err = 2'b01; dn_rdata = {32'h0, 32'hDEADBEEF};
        #1;
        chk("wr0_done_rdy", 32'(up_rdy), 32'h1);
        chk("wr0_done_err", 32'(up_err), 32'h1);
        cyc();
        dn_rdy = 2'b00; dn_err = 2'b00; dn_rdata = 64'd0;
        #1;
        chk("wr0_err_once", 32'(up_err), 32'h0);
        chk("wr0_rdata_kept", up_rdata, 32'hCAFEF00D);

        // Read AP1 answering on the first busy cycle, no error
        cyc();
        up_ren = 1'b1; up_sel = 8'd1; dn_rdy = 2'b10; dn_rdata = {32'h0BADF00D, 32'h0};
        #1;
        chk("rd2_dn_ren", 32'(dn_ren), 32'h2);
        cyc();
        up_ren = 1'b0;
        #1;
        chk("rd2_rdy", 32'(up_rdy), 32'h1);
        chk("rd2_err", 32'(up_err), 32'h0);
        chk("rd2_rdata", up_rdata, 32'h0BADF00D);
        cyc();
        dn_rdy = 2'b00; dn_rdata = 64'd0;

        // Unimplemented APSEL
        cyc();
        up_ren = 1'b1; up_sel = 8'h05;
        #1;
        chk("null_dn_ren", 32'(dn_ren), 32'h0);
        chk("null_dn_wen", 32'(dn_wen), 32'h0);
        cyc();
        up_ren = 1'b0;
        #1;
        chk("null_rdy", 32'(up_rdy), 32'h1);
        chk("null_rdata", up_rdata, 32'h0);
        chk("null_err_u0", 32'(up_err), 32'h0);
        chk("null_err_u1", 32'(u1_up_err), 32'h1);
        cyc();
        chk("null_rdata_cleared", up_rdata, 32'h0);
        chk("null_u1_err_once", 32'(u1_up_err), 32'h0);

        // Watchdog: AP1 never ready
        cyc();
        up_ren = 1'b1; up_sel = 8'd1; dn_rdy = 2'b00;
        #1;
        chk("to_issue_abort", 32'(dn_abort), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            up_ren = 1'b0;
            #1;
            chk("to_busy_rdy", 32'(up_rdy), 32'h0);
            chk("to_abort", 32'(dn_abort), (k == 8) ? 32'h2 : 32'h0);
        end
        cyc();
        chk("to_tout_rdy", 32'(up_rdy), 32'h1);
        chk("to_tout_err", 32'(up_err), 32'h1);
        chk("to_tout_rdata", up_rdata, 32'h0);
        chk("to_tout_abort", 32'(dn_abort), 32'h0);
        cyc();
        chk("to_idle_err", 32'(up_err), 32'h0);

        // Host abort while AP0 stalls
        cyc();
        up_ren = 1'b1; up_sel = 8'd0;
        #1;
        chk("ab_dn_ren", 32'(dn_ren), 32'h1);
        cyc();
        up_ren = 1'b0;
        #1;
        chk("ab_busy_rdy", 32'(up_rdy), 32'h0);
        cyc();
        up_abort = 1'b1;
        #1;
        chk("ab_dn_abort", 32'(dn_abort), 32'h3);
        cyc();
        up_abort = 1'b0;
        #1;
        chk("ab_after_rdy", 32'(up_rdy), 32'h1);
        chk("ab_after_err", 32'(up_err), 32'h0);
        chk("ab_after_abort", 32'(dn_abort), 32'h0);
        cyc();
        up_ren = 1'b1; up_sel = 8'd0;
        #1;
        chk("ab_rd_dn_ren", 32'(dn_ren), 32'h1);
        cyc();
        up_ren = 1'b0; dn_rdy = 2'b01; dn_rdata = {32'h0, 32'h55AA1234};
        #1;
        chk("ab_rd_rdy", 32'(up_rdy), 32'h1);
        chk("ab_rd_rdata", up_rdata, 32'h55AA1234);
        chk("ab_rd_err", 32'(up_err), 32'h0);
        cyc();
        dn_rdy = 2'b00; dn_rdata = 64'd0;
        #1;
        chk("ab_rd_hold", up_rdata, 32'h55AA1234);

        // Abort together with a write request: abort wins
        cyc();
        up_wen = 1'b1; up_sel = 8'd1; up_abort = 1'b1;
        #1;
        chk("abw_dn_wen", 32'(dn_wen), 32'h0);
        chk("abw_dn_abort", 32'(dn_abort), 32'h3);
        cyc();
        up_wen = 1'b0; up_abort = 1'b0;
        #1;
        chk("abw_stay_idle", 32'(up_rdy), 32'h1);

        // Reset mid-access
        cyc();
        up_ren = 1'b1; up_sel = 8'd1;
        cyc();
        up_ren = 1'b0;
        #1;
        chk("rb_busy_rdy", 32'(up_rdy), 32'h0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rb_in_rst_abort", 32'(dn_abort), 32'h0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rb_after_rdy", 32'(up_rdy), 32'h1);
        chk("rb_after_rdata", up_rdata, 32'h0);
        chk("rb_after_abort", 32'(dn_abort), 32'h0);
        cyc();
        up_wen = 1'b1; up_sel = 8'd1; up_wdata = 32'h0000A5A5;
        #1;
        chk("rb_wr_dn_wen", 32'(dn_wen), 32'h2);
        chk("rb_wr_dn_wdata", dn_wdata, 32'h0000A5A5);
        cyc();
        up_wen = 1'b0; dn_rdy = 2'b10;
        #1;
        chk("rb_wr_rdy", 32'(up_rdy), 32'h1);
        chk("rb_wr_err", 32'(up_err), 32'h0);
        cyc();
        dn_rdy = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
